// File: rtl/sbs_to_bin_if.sv
// rtl/sbs_to_bin_if.sv - bitstream-in / binary-out handshake bundle for sbs_to_bin
interface sbs_to_bin_if #(
    parameter int BSL = 255,
    parameter int CW  = $clog2(BSL + 1)
);
    logic [BSL-1:0] a_sbs;
    logic           sbs_valid;
    logic           sbs_ready;
    logic [CW-1:0]  a_bin;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output a_sbs, sbs_valid, out_ready,
        input  sbs_ready, a_bin, out_valid
    );

    modport slave (
        input  a_sbs, sbs_valid, out_ready,
        output sbs_ready, a_bin, out_valid
    );
endinterface

// File: rtl/sbs_to_bin.sv
// rtl/sbs_to_bin.sv - stochastic bitstream to binary popcount converter (optional SBS2BIN_OVERRUN_EN)
module sbs_to_bin #(
    parameter int BSL   = 255,
    parameter int LANES = 8,
    parameter int CW    = $clog2(BSL + 1)
) (
    input  logic           clk,
    input  logic           rst,
    sbs_to_bin_if.slave    bus,
    output logic           busy
`ifdef SBS2BIN_OVERRUN_EN
    ,
    output logic           overrun
`endif
);
    localparam int NCHUNK = (BSL + LANES - 1) / LANES;
    localparam int CHW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    state_t         state;
    logic [BSL-1:0] shift;
    logic [CW-1:0]  acc;
    logic [CHW-1:0] chunk;
    logic [CW-1:0]  lane_sum;
    logic [CW-1:0]  acc_next;

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + CW'(shift[i]);
        end
        acc_next = acc + lane_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            shift         <= '0;
            acc           <= '0;
            chunk         <= '0;
            bus.a_bin     <= '0;
            bus.sbs_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.sbs_valid) begin
                        shift         <= bus.a_sbs;
                        acc           <= '0;
                        chunk         <= '0;
                        state         <= COUNT;
                        bus.sbs_ready <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                COUNT: begin
                    acc   <= acc_next;
                    shift <= shift >> LANES;
                    chunk <= chunk + 1'b1;
                    // Result is published on the same edge that sums the final chunk.
                    if (chunk == CHW'(NCHUNK - 1)) begin
                        bus.a_bin     <= acc_next;
                        bus.out_valid <= 1'b1;
                        busy          <= 1'b0;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.sbs_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.sbs_ready <= 1'b1;
                    bus.out_valid <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

`ifdef SBS2BIN_OVERRUN_EN
    logic sbs_valid_q;

    // A fresh done from the generator while we are still busy means a bitstream was dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sbs_valid_q <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            sbs_valid_q <= bus.sbs_valid;
            if (bus.sbs_valid && !sbs_valid_q && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end
`endif
endmodule
